// File: rtl/anim_sequencer.sv
// anim_sequencer: animation frame scheduler advancing frame_index on a programmable period, applied at vblank_start
// Ports: px_clk/reset (async, active-high); vblank_start pulse; cmd_valid/cmd_ready/cmd_op/cmd_arg command port
// (0=PLAY 1=PAUSE 2=STEP 3=SET_PERIOD); frame_index, frame_tick, running outputs.
module anim_sequencer #(
    parameter int NUM_FRAMES     = 12,
    parameter int PERIOD_W       = 22,
    parameter int DEFAULT_PERIOD = 2_835_000
) (
    input  logic                          px_clk,
    input  logic                          reset,
    input  logic                          vblank_start,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [PERIOD_W-1:0]           cmd_arg,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_index,
    output logic                          frame_tick,
    output logic                          running
);
    localparam int IW = $clog2(NUM_FRAMES);
    localparam logic [1:0] OP_PLAY = 2'd0, OP_PAUSE = 2'd1, OP_STEP = 2'd2, OP_SET = 2'd3;
    typedef enum logic [1:0] {RUN, PAUSED, STEP_WAIT} state_t;
    state_t state, state_d;
    logic [PERIOD_W-1:0] period_q, period_d, count_q, count_d;
    logic [IW-1:0] index_d;
    logic pending_q, pending_d, expiry, advance, fire;
    always_comb begin
        fire    = cmd_valid && cmd_ready;
        expiry  = state == RUN && count_q == period_q - PERIOD_W'(1);
        // advance decision uses the pre-command state, so a same-cycle PAUSE still honours a pending advance
        advance = vblank_start && ((state == RUN && (pending_q || expiry)) || state == STEP_WAIT);
        state_d = state;
        if (state == STEP_WAIT && vblank_start)
            state_d = PAUSED;
        else if (fire && cmd_op == OP_PLAY && state == PAUSED)
            state_d = RUN;
        else if (fire && cmd_op == OP_PAUSE && state == RUN)
            state_d = PAUSED;
        else if (fire && cmd_op == OP_STEP && state == PAUSED)
            state_d = STEP_WAIT;
        count_d   = (fire && cmd_op == OP_SET) ? '0 : state != RUN ? count_q : expiry ? '0 : count_q + PERIOD_W'(1);
        pending_d = (advance || (fire && cmd_op == OP_PAUSE)) ? 1'b0 : expiry ? 1'b1 : pending_q;
        period_d  = (fire && cmd_op == OP_SET) ? (cmd_arg < PERIOD_W'(2) ? PERIOD_W'(2) : cmd_arg) : period_q;
        index_d   = !advance ? frame_index : frame_index == IW'(NUM_FRAMES - 1) ? '0 : frame_index + IW'(1);
    end
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            period_q    <= PERIOD_W'(DEFAULT_PERIOD);
            count_q     <= '0;
            pending_q   <= 1'b0;
            frame_index <= '0;
            frame_tick  <= 1'b0;
        end else begin
            state       <= state_d;
            period_q    <= period_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            frame_index <= index_d;
            frame_tick  <= advance;
        end
    end
    assign cmd_ready = state != STEP_WAIT;
    assign running   = state == RUN;
endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: directed plus randomized checks of anim_sequencer against a behavioural model
module tb_anim_sequencer;
    localparam int NF = 12;
    localparam int PW = 22;
    localparam int DP = 6;
    localparam int IW = $clog2(NF);
    localparam logic [1:0] PLAY = 2'd0, PAUSE = 2'd1, STEP = 2'd2, SETP = 2'd3;
    localparam int M_RUN = 0, M_PAUSED = 1, M_STEP = 2;

    logic px_clk = 1'b0;
    logic reset = 1'b1;
    logic vblank_start = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [PW-1:0] cmd_arg = '0;
    logic [IW-1:0] frame_index;
    logic frame_tick;
    logic running;

    int n_cmp = 0;
    int n_bad = 0;
    int m_frame, m_count, m_period, m_mode;
    bit m_pend;

    anim_sequencer #(.NUM_FRAMES(NF), .PERIOD_W(PW), .DEFAULT_PERIOD(DP)) dut (
        .px_clk(px_clk), .reset(reset), .vblank_start(vblank_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .frame_index(frame_index), .frame_tick(frame_tick), .running(running)
    );

    always #5 px_clk = ~px_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit tick);
        chk({tag, ".frame_index"}, 32'(frame_index), 32'(m_frame));
        chk({tag, ".frame_tick"}, 32'(frame_tick), 32'(tick));
        chk({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(m_mode != M_STEP));
    endtask

    task automatic model_reset();
        m_frame = 0; m_count = 0; m_period = DP; m_mode = M_RUN; m_pend = 0;
    endtask

    // one px_clk cycle: drive inputs, predict the outcome, check after the edge
    task automatic cyc(input string tag, input bit vb, input bit v, input logic [1:0] op, input int arg);
        bit fire, expd, adv;
        vblank_start = vb; cmd_valid = v; cmd_op = op; cmd_arg = PW'(arg);
        fire = v && m_mode != M_STEP;
        expd = m_mode == M_RUN && m_count + 1 == m_period;
        adv  = vb && ((m_mode == M_RUN && (m_pend || expd)) || m_mode == M_STEP);
        if (adv) m_frame = (m_frame + 1) % NF;
        if (m_mode == M_RUN) m_count = expd ? 0 : m_count + 1;
        if (adv) m_pend = 0;
        else if (expd) m_pend = 1;
        if (fire && op == SETP) begin
            m_period = arg < 2 ? 2 : arg;
            m_count = 0;
        end
        if (fire && op == PAUSE) m_pend = 0;
        if (m_mode == M_STEP) begin
            if (vb) m_mode = M_PAUSED;
        end else if (fire && op == PLAY) m_mode = M_RUN;
        else if (fire && op == PAUSE) m_mode = M_PAUSED;
        else if (fire && op == STEP && m_mode == M_PAUSED) m_mode = M_STEP;
        @(posedge px_clk);
        #1;
        chk_all(tag, adv);
        vblank_start = 0; cmd_valid = 0;
    endtask

    initial begin
        // reset values
        model_reset();
        #2;
        chk_all("reset", 0);
        @(posedge px_clk);
        #1 reset = 0;
        // default period, vblank every 4 cycles
        for (int i = 0; i < 24; i++) cyc("default", i % 4 == 3, 0, PLAY, 0);
        // period 4, vblank every 10: one step per vblank with wrap
        cyc("set4", 0, 1, SETP, 4);
        for (int i = 0; i < 140; i++) cyc("p4v10", i % 10 == 9, 0, PLAY, 0);
        // period 20, vblank every 5: only one advance per expiry
        cyc("set20", 0, 1, SETP, 20);
        for (int i = 0; i < 120; i++) cyc("p20v5", i % 5 == 4, 0, PLAY, 0);
        // pause then vblanks: index holds
        cyc("pause", 0, 1, PAUSE, 0);
        for (int i = 0; i < 50; i++) cyc("paused", i % 10 == 9, 0, PLAY, 0);
        // single step
        cyc("step", 0, 1, STEP, 0);
        for (int i = 0; i < 5; i++) cyc("stepwait", 0, 1, PAUSE, 0);
        cyc("stepvb", 1, 0, PLAY, 0);
        cyc("afterstep", 1, 0, PLAY, 0);
        // resume, wait for a pending advance, pause on the vblank cycle
        cyc("play", 0, 1, PLAY, 0);
        for (int i = 0; i < 40 && !m_pend; i++) cyc("topend", 0, 0, PLAY, 0);
        chk("pending_reached", 32'(m_pend), 32'd1);
        cyc("pausevb", 1, 1, PAUSE, 0);
        for (int i = 0; i < 12; i++) cyc("heldpause", i % 3 == 0, 0, PLAY, 0);
        cyc("replay", 0, 1, PLAY, 0);
        for (int i = 0; i < 60; i++) cyc("resumed", i % 7 == 6, 0, PLAY, 0);
        // period floor of 2
        cyc("set0", 0, 1, SETP, 0);
        for (int i = 0; i < 20; i++) cyc("p2", 1, 0, PLAY, 0);
        cyc("set1", 0, 1, SETP, 1);
        for (int i = 0; i < 10; i++) cyc("p2b", i % 2 == 0, 0, PLAY, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc("rand", $urandom_range(5) == 0, $urandom_range(7) == 0,
                2'($urandom_range(3)), int'($urandom_range(15)));
        // drive to STEP_WAIT with index 7, then reset asynchronously
        for (int i = 0; i < 40 && m_frame != 7; i++) begin
            cyc("to7p", 0, 1, PAUSE, 0);
            cyc("to7s", 0, 1, STEP, 0);
            cyc("to7v", 1, 0, PLAY, 0);
        end
        chk("reached7", 32'(m_frame), 32'd7);
        cyc("finalstep", 0, 1, STEP, 0);
        chk("in_stepwait", 32'(m_mode), 32'(M_STEP));
        #2 reset = 1;
        model_reset();
        #1;
        chk_all("midreset", 0);
        @(posedge px_clk);
        #1;
        chk_all("midreset_hold", 0);
        reset = 0;
        for (int i = 0; i < 20; i++) cyc("postreset", i % 4 == 3, 0, PLAY, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Frame scheduler for the Nyancat renderer. Owns the animation frame index consumed by the frame-ROM address generator and advances it on a programmable period. Index changes are applied only at the start of vertical blanking, so a displayed frame never mixes two animation frames. A valid/ready command port lets a host or debug controller play, pause, single-step or retime the animation.

## Interface
Parameters:
- NUM_FRAMES, 12: number of animation frames; frame_index wraps NUM_FRAMES-1 -> 0.
- PERIOD_W, 22: width of the period counter and of cmd_arg.
- DEFAULT_PERIOD, 2_835_000: period loaded at reset, in px_clk cycles (~90 ms at 31.5 MHz).

Ports:
- px_clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- vblank_start  in  1  one-cycle pulse on the first cycle of vertical blanking.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=PLAY, 1=PAUSE, 2=STEP, 3=SET_PERIOD.
- cmd_arg  in  PERIOD_W  new period for SET_PERIOD; ignored otherwise.
- frame_index  out  $clog2(NUM_FRAMES)  current animation frame.
- frame_tick  out  1  one-cycle pulse in the first cycle of a new frame_index value.
- running  out  1  high in state RUN.

## Operation
- Registers:
  - state {RUN, PAUSED, STEP_WAIT}
  - period_q [PERIOD_W]
  - count_q [PERIOD_W]
  - pending_q (one advance owed)
  - frame_index
- Reset values:
  - state=RUN
  - period_q=DEFAULT_PERIOD
  - count_q=0
  - pending_q=0
  - frame_index=0
  - frame_tick=0
  - running=1
  - cmd_ready=1
- RUN behaviour:
  - count_q increments each cycle.
  - When count_q==period_q-1, count_q wraps to 0 and pending_q is set.
  - Repeated expiries before a vblank do not queue extra advances; pending_q is a flag, not a counter.
- Advance: on a vblank_start cycle in RUN with (pending_q || expiry in that same cycle), or in STEP_WAIT:
  - frame_index advances by 1 with wrap.
  - pending_q clears.
  - frame_tick pulses.
- PAUSED: count_q holds, no advances occur, and pending_q stays 0.
- Commands (all are accepted when cmd_ready=1):
  - PLAY: PAUSED->RUN; count_q resumes from its held value. No-op in RUN.
  - PAUSE: RUN->PAUSED; clears pending_q. No-op in PAUSED.
  - STEP: PAUSED->STEP_WAIT. Accepted and ignored in RUN.
  - SET_PERIOD: period_q <= max(cmd_arg, 2); count_q <= 0; pending_q unchanged; state unchanged. Allowed in RUN and PAUSED.
- STEP_WAIT:
  - cmd_ready=0.
  - At the next vblank_start, advance once and go to PAUSED.
- Same-cycle command and vblank: the advance decision uses the pre-command state. A PAUSE accepted on a vblank_start cycle with pending_q=1 still advances, then the block is PAUSED.
- Arithmetic: all unsigned. The comparison count_q==period_q-1 uses PERIOD_W bits. period_q is never below 2, so there is no underflow.

## Timing
- All outputs are registered. cmd_ready and running decode registered state.
- frame_index changes, and frame_tick is high, in the cycle after vblank_start is sampled high.
- A command accepted at edge N takes effect on registers at edge N; the new state is visible in cycle N+1.
- Expiry at cycle N with vblank_start also at N advances the index at N+1 (no extra latency).
- Reset mid-operation: all registers return asynchronously to their reset values. Any pending advance or STEP is dropped.

## Test plan
- Reset, SET_PERIOD 4, vblank_start every 10 cycles -> frame_index 0,1,2,… exactly one step per vblank, frame_tick high 1 cycle each, wraps 11->0.
- SET_PERIOD 20, vblank_start every 5 cycles -> index advances only on the first vblank after every 20 cycles; there are never two advances from one expiry.
- PAUSE in RUN, 5 vblanks -> index constant, running=0. Then STEP -> cmd_ready=0 until the next vblank, index+1, state PAUSED, cmd_ready=1.
- PAUSE issued on the same cycle as vblank_start with pending_q=1 -> index advances once, then holds. PLAY -> count_q resumes from its held value.
- SET_PERIOD 0 -> period_q=2; expiry every 2 cycles.
- Assert reset with STEP_WAIT and index=7 -> frame_index=0, running=1, cmd_ready=1 immediately, no frame_tick.
